// File: rtl/nav_pkg.sv
// Shared types and constants for the parametrised navigation controller.
// The key decoder is sized for the widest supported keypad.
package nav_pkg;

  typedef enum logic [2:0] {ROOT, LOAD, MENU, ARM, ACT, END} state_t;

  localparam int          KEYS_MAX = 16;
  localparam int          LOC_ROOT = 0;
  localparam logic [15:0] END_CODE = 16'hFFFF;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } key_sel_t;

  // A pattern is a usable key press only when exactly one bit is set.
  function automatic key_sel_t onehot_idx(input logic [KEYS_MAX-1:0] k);
    key_sel_t r;
    r.valid = 1'b0;
    r.idx   = 4'd0;
    for (int i = 0; i < KEYS_MAX; i++) begin
      if (k == (KEYS_MAX'(1) << i)) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nav_action_timer.sv
// Counts cycles spent in an action and flags the last allowed cycle.
// A zero timeout removes the counter entirely.
module nav_action_timer #(
  parameter int ACT_TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (ACT_TIMEOUT == 0) begin : g_off
    logic unused_ins;
    assign unused_ins = ^{clk, reset, clear, enable};
    assign expired    = 1'b0;
  end else begin : g_on
    localparam int CW = ($clog2(ACT_TIMEOUT + 1) > 1) ? $clog2(ACT_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACT_TIMEOUT - 1);

    logic [CW-1:0] count;

    // Saturates on the last allowed cycle so a held-off exit never wraps.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count <= '0;
      end else if (clear) begin
        count <= '0;
      end else if (enable && count != LAST) begin
        count <= count + CW'(1);
      end
    end

    assign expired = enable && (count == LAST);
  end

endmodule

// File: rtl/nav_fsm_param.sv
// Multi-location navigation controller with background-load handshake,
// per-location action enables and an optional action timeout.
module nav_fsm_param
  import nav_pkg::*;
#(
  parameter int                      NUM_LOC     = 3,
  parameter int                      KEYS        = 3,
  parameter int                      LOC_W       = 4,
  parameter int                      ACT_W       = 4,
  parameter logic [NUM_LOC*KEYS-1:0] ACT_EN      = '1,
  parameter int                      ACT_TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [KEYS-1:0] keys,
  input  logic            load_ack,
  input  logic            done_action,
  input  logic            game_end,
  output logic            transition,
  output logic [LOC_W-1:0] location,
  output logic [ACT_W-1:0] action,
  output logic            load_req,
  output logic            action_start,
  output logic            timed_out
);

  state_t state, state_next;
  logic [LOC_W-1:0] location_next;
  logic [ACT_W-1:0] action_next;
  logic ack_seen, ack_seen_next;
  logic transition_next, load_req_next, action_start_next, timed_out_next;
  logic released, key0, act_enabled, expired;
  key_sel_t sel;

  assign sel      = onehot_idx(KEYS_MAX'(keys));
  assign released = (keys == '0);
  assign key0     = sel.valid && (sel.idx == 4'd0);

  nav_action_timer #(
    .ACT_TIMEOUT (ACT_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ACT),
    .enable  (state == ACT),
    .expired (expired)
  );

  // Look up the enable bit for the pressed key in the current location.
  always_comb begin
    act_enabled = 1'b0;
    for (int l = 1; l <= NUM_LOC; l++) begin
      for (int k = 1; k < KEYS; k++) begin
        if (sel.valid && location == LOC_W'(l) && sel.idx == 4'(k)) begin
          act_enabled = ACT_EN[(l-1)*KEYS + k];
        end
      end
    end
  end

  always_comb begin
    state_next        = state;
    location_next     = location;
    action_next       = action;
    ack_seen_next     = ack_seen;
    action_start_next = 1'b0;
    timed_out_next    = 1'b0;

    case (state)
      ROOT: begin
        if (key0) begin
          state_next    = LOAD;
          location_next = LOC_W'(1);
          ack_seen_next = 1'b0;
        end
      end
      LOAD: begin
        action_next   = '0;
        ack_seen_next = ack_seen | load_ack;
        if ((ack_seen || load_ack) && released) begin
          state_next = MENU;
        end
      end
      MENU: begin
        if (key0) begin
          state_next    = LOAD;
          location_next = (location == LOC_W'(NUM_LOC)) ? LOC_W'(1) : location + LOC_W'(1);
          ack_seen_next = 1'b0;
        end else if (act_enabled) begin
          state_next  = ARM;
          action_next = ACT_W'(sel.idx);
        end
      end
      ARM: begin
        if (released) begin
          state_next        = ACT;
          action_start_next = 1'b1;
        end
      end
      ACT: begin
        // A completed action beats a timeout landing on the same cycle.
        if (done_action) begin
          state_next    = LOAD;
          action_next   = '0;
          ack_seen_next = 1'b0;
        end else if (expired) begin
          state_next     = LOAD;
          action_next    = '0;
          ack_seen_next  = 1'b0;
          timed_out_next = 1'b1;
        end
      end
      END: begin
        location_next = END_CODE[LOC_W-1:0];
        action_next   = END_CODE[ACT_W-1:0];
      end
      default: begin
        state_next    = ROOT;
        location_next = LOC_W'(LOC_ROOT);
        action_next   = '0;
      end
    endcase

    if (game_end) begin
      state_next        = END;
      location_next     = END_CODE[LOC_W-1:0];
      action_next       = END_CODE[ACT_W-1:0];
      action_start_next = 1'b0;
      timed_out_next    = 1'b0;
    end

    transition_next = (state_next == LOAD) || (state_next == ARM) || (state_next == END);
    load_req_next   = (state_next == LOAD) && !ack_seen_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ROOT;
      location     <= LOC_W'(LOC_ROOT);
      action       <= '0;
      ack_seen     <= 1'b0;
      transition   <= 1'b0;
      load_req     <= 1'b0;
      action_start <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      state        <= state_next;
      location     <= location_next;
      action       <= action_next;
      ack_seen     <= ack_seen_next;
      transition   <= transition_next;
      load_req     <= load_req_next;
      action_start <= action_start_next;
      timed_out    <= timed_out_next;
    end
  end

endmodule
